// File: rtl/tcm_arbiter_if.sv
// Bus bundle for tcm_arbiter: AHB-Lite slave side, DMA req/gnt port and SRAM macro pins.
// slave is the arbiter's view; master is the environment (AHB master, DMA engine, SRAM).
interface tcm_arbiter_if #(
  parameter int unsigned AW = 14
);
  logic          hsel;
  logic [31:0]   haddr;
  logic [1:0]    htrans;
  logic [2:0]    hsize;
  logic          hwrite;
  logic          hready;
  logic [31:0]   hwdata;
  logic          hreadyout;
  logic          hresp;
  logic [31:0]   hrdata;

  logic          dma_req;
  logic          dma_we;
  logic [3:0]    dma_be;
  logic [AW-1:0] dma_addr;
  logic [31:0]   dma_wdata;
  logic          dma_gnt;
  logic          dma_rvalid;
  logic [31:0]   dma_rdata;

  logic          sram_cs;
  logic [3:0]    sram_we;
  logic [AW-1:0] sram_addr;
  logic [31:0]   sram_wdata;
  logic [31:0]   sram_rdata;

  modport slave (
    input  hsel, haddr, htrans, hsize, hwrite, hready, hwdata,
    output hreadyout, hresp, hrdata,
    input  dma_req, dma_we, dma_be, dma_addr, dma_wdata,
    output dma_gnt, dma_rvalid, dma_rdata,
    output sram_cs, sram_we, sram_addr, sram_wdata,
    input  sram_rdata
  );

  modport master (
    output hsel, haddr, htrans, hsize, hwrite, hready, hwdata,
    input  hreadyout, hresp, hrdata,
    output dma_req, dma_we, dma_be, dma_addr, dma_wdata,
    input  dma_gnt, dma_rvalid, dma_rdata,
    input  sram_cs, sram_we, sram_addr, sram_wdata,
    output sram_rdata
  );
endinterface

// File: rtl/tcm_arbiter.sv
// Single-port TCM controller arbitrating one SRAM between AHB-Lite (priority) and a DMA port.
// Define TCM_ARB_STATS_EN to add stall_cnt/stall_clr (PEND cycles lost to DMA).
module tcm_arbiter #(
  parameter int unsigned AW           = 14,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic         clk,
  input  logic         rstn,
`ifdef TCM_ARB_STATS_EN
  input  logic         stall_clr,
  output logic [15:0]  stall_cnt,
`endif
  tcm_arbiter_if.slave bus
);
  typedef enum logic [1:0] {StIdle, StPend, StRdata} state_e;

  localparam logic [3:0] Limit = 4'(STARVE_LIMIT);

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q;
  logic [3:0]    be_q, cap_be;
  logic          write_q;
  logic [3:0]    starve_q, starve_d;
  logic          dma_rvalid_q;
  logic          capture, ahb_want, dma_win, ahb_win;
  logic          unused_bits;

  assign unused_bits = ^{bus.haddr[31:AW+2], bus.htrans[0]};

  assign capture = bus.hsel & bus.hready & bus.htrans[1];

  always_comb begin
    cap_be = 4'b1111;
    case (bus.hsize)
      3'd0:    cap_be = 4'b0001 << bus.haddr[1:0];
      3'd1:    cap_be = bus.haddr[1] ? 4'b1100 : 4'b0011;
      default: cap_be = 4'b1111;
    endcase
  end

  assign ahb_want = (state_q == StPend);
  // rstn gates the DMA path so no SRAM access escapes while reset is held.
  assign dma_win  = rstn & bus.dma_req & (~ahb_want | (starve_q == Limit));
  assign ahb_win  = ahb_want & ~dma_win;

  always_comb begin
    state_d        = state_q;
    bus.hreadyout  = 1'b1;
    bus.hrdata     = '0;
    bus.sram_cs    = dma_win | ahb_win;
    bus.sram_we    = '0;
    bus.sram_addr  = '0;
    bus.sram_wdata = '0;
    if (dma_win) begin
      bus.sram_we    = bus.dma_we ? bus.dma_be : 4'b0000;
      bus.sram_addr  = bus.dma_addr;
      bus.sram_wdata = bus.dma_wdata;
    end else if (ahb_win) begin
      bus.sram_we    = write_q ? be_q : 4'b0000;
      bus.sram_addr  = addr_q;
      bus.sram_wdata = bus.hwdata;
    end
    case (state_q)
      StIdle: begin
        if (capture) state_d = StPend;
      end
      StPend: begin
        if (ahb_win && write_q) begin
          state_d = capture ? StPend : StIdle;
        end else if (ahb_win) begin
          bus.hreadyout = 1'b0;
          state_d       = StRdata;
        end else begin
          bus.hreadyout = 1'b0;
        end
      end
      StRdata: begin
        bus.hrdata = bus.sram_rdata;
        state_d    = capture ? StPend : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    starve_d = '0;
    if (bus.dma_req && !dma_win) begin
      starve_d = (starve_q == Limit) ? starve_q : starve_q + 4'd1;
    end
  end

  assign bus.hresp      = 1'b0;
  assign bus.dma_gnt    = dma_win;
  assign bus.dma_rvalid = dma_rvalid_q;
  assign bus.dma_rdata  = dma_rvalid_q ? bus.sram_rdata : 32'h0;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      be_q         <= '0;
      write_q      <= 1'b0;
      starve_q     <= '0;
      dma_rvalid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_q     <= starve_d;
      dma_rvalid_q <= dma_win & ~bus.dma_we;
      if (capture) begin
        addr_q  <= bus.haddr[AW+1:2];
        be_q    <= cap_be;
        write_q <= bus.hwrite;
      end
    end
  end

`ifdef TCM_ARB_STATS_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_q <= '0;
    end else if (stall_clr) begin
      stall_q <= '0;
    end else if (ahb_want && dma_win && stall_q != 16'hffff) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cnt = stall_q;
`endif
endmodule
